// File: rtl/ahb2apb_bridge_if.sv
// Bus bundle between an AHB-Lite master and the AHB-to-APB bridge, plus the
// APB side facing the peripherals. The bridge sits on the "slave" modport.
//
// Handshake: an AHB address phase is taken at a PCLK edge when
// HSEL & HTRANS[1] & HREADY are all 1. The bridge stretches the data phase by
// holding HREADYOUT low and ends it in the cycle HREADYOUT returns to 1. HRESP
// and HRDATA are meaningful in that cycle. APB runs SETUP (PSEL only), then
// ACCESS (PSEL & PENABLE), for exactly one cycle each. There is no PREADY.
interface ahb2apb_bridge_if #(
  parameter int NSLV = 3
);
  logic                   HSEL;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [31:0]            HADDR;
  logic [31:0]            HWDATA;
  logic                   HREADY;
  logic                   HREADYOUT;
  logic                   HRESP;
  logic [31:0]            HRDATA;
  logic [NSLV-1:0]        PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [31:0]            PADDR;
  logic [31:0]            PWDATA;
  logic [32*NSLV-1:0]     PRDATA_BUS;

  modport slave (
    input  HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY, PRDATA_BUS,
    output HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport master (
    output HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY, PRDATA_BUS,
    input  HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB2 initiator bridge. Each accepted AHB transfer becomes
// one APB SETUP/ACCESS pair for the peripheral chosen by an HADDR index field;
// an unmapped index gets a two-cycle AHB ERROR response and no APB cycle.
module ahb2apb_bridge #(
  parameter int NSLV    = 3,
  parameter int IDXW    = 2,
  parameter int SEL_LSB = 12
) (
  input  logic                 PCLK,
  input  logic                 PRST_N,
  ahb2apb_bridge_if.slave      bus,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  localparam logic [IDXW:0] NSLV_W = (IDXW+1)'(NSLV);

  state_t            state_q, state_d;
  logic [31:0]       paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              accept;
  logic [IDXW-1:0]   haddr_idx;
  logic              unmapped;
  logic [31:0]       rd_slice;
  logic              hreadyout;
  logic              hresp;
  logic              penable;
  logic              sel_on;
  logic [NSLV-1:0]   psel;
  logic              unused_htrans0;

  assign haddr_idx      = bus.HADDR[SEL_LSB +: IDXW];
  assign unmapped       = ({1'b0, haddr_idx} >= NSLV_W);
  assign accept         = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign unused_htrans0 = bus.HTRANS[0];

  // Pick the read bus slice of the currently addressed peripheral.
  always_comb begin
    rd_slice = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == IDXW'(k)) rd_slice = bus.PRDATA_BUS[32*k +: 32];
    end
  end

  // Next-state and per-state bus outputs; outputs depend only on state so
  // an asynchronous reset clears them immediately.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    idx_d     = idx_q;
    pwdata_d  = pwdata_q;
    hrdata_d  = hrdata_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    penable   = 1'b0;
    sel_on    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          paddr_d  = bus.HADDR;
          pwrite_d = bus.HWRITE;
          idx_d    = haddr_idx;
          if (unmapped)        state_d = S_ERR1;
          else if (bus.HWRITE) state_d = S_WDATA;
          else                 state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        hreadyout = 1'b0;
        pwdata_d  = bus.HWDATA;
        state_d   = S_SETUP;
      end
      S_SETUP: begin
        hreadyout = 1'b0;
        sel_on    = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        hreadyout = 1'b0;
        sel_on    = 1'b1;
        penable   = 1'b1;
        if (!pwrite_q) hrdata_d = rd_slice;
        state_d   = S_DONE;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        // A transfer presented alongside the second ERROR cycle is dropped.
        hresp   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-hot peripheral select during the SETUP and ACCESS cycles only.
  always_comb begin
    psel = '0;
    for (int k = 0; k < NSLV; k++) begin
      psel[k] = sel_on && (idx_q == IDXW'(k));
    end
  end

  // State and latched transfer attributes, cleared asynchronously.
  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed scenarios followed by random AHB traffic.
// The driver pushes expected AHB responses and APB cycles into queues; two
// negedge monitors pop and compare as the bridge produces them.
module tb_ahb2apb_bridge;

  localparam int NSLV = 3;
  localparam int RW   = 36;  // {hresp, waits[2:0], hrdata}
  localparam int AW   = 67;  // {idx[1:0], write, addr, wdata}

  logic       PCLK;
  logic       PRST_N;
  logic [2:0] dut_state;

  ahb2apb_bridge_if #(.NSLV(NSLV)) bus ();

  assign bus.HREADY = bus.HREADYOUT;

  ahb2apb_bridge #(.NSLV(NSLV), .IDXW(2), .SEL_LSB(12)) dut (
    .PCLK    (PCLK),
    .PRST_N  (PRST_N),
    .bus     (bus),
    .state_o (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [AW-1:0] apb_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [31:0]   slv_rd[NSLV];
  logic [31:0]   last_rd;
  bit            last_was_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle_cycle();
    bus.HSEL   = 1'($urandom_range(0, 1));
    bus.HTRANS = 2'($urandom_range(0, 1));
    bus.HWRITE = 1'($urandom_range(0, 1));
    bus.HADDR  = $urandom;
    @(posedge PCLK); #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, input int gap);
    int          n;
    int          idx;
    bit          ignored;
    logic [2:0]  waits;
    logic        resp;
    logic [32*NSLV-1:0] rbus;
    n = 0;
    while (!bus.HREADYOUT && n < 50) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("ready_timeout", {63'd0, bus.HREADYOUT}, 64'd1);
    for (int g = 0; g < gap; g++) idle_cycle();
    for (int k = 0; k < NSLV; k++) rbus[32*k +: 32] = slv_rd[k];
    bus.PRDATA_BUS = rbus;
    idx     = int'(a[13:12]);
    ignored = last_was_err && (gap == 0);
    if (ignored) begin
      resp = 1'b0; waits = 3'd0; last_was_err = 1'b0;
    end else if (idx >= NSLV) begin
      resp = 1'b1; waits = 3'd1; last_was_err = 1'b1;
    end else begin
      resp = 1'b0; waits = w ? 3'd3 : 3'd2; last_was_err = 1'b0;
      if (!w) last_rd = slv_rd[idx];
      apb_q.push_back({2'(idx), w, a, wd});
    end
    exp_q.push_back({resp, waits, last_rd});
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10 | 2'($urandom_range(0, 1));
    bus.HWRITE = w;
    bus.HADDR  = a;
    @(posedge PCLK); #1;
    bus.HWDATA = wd;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'($urandom_range(0, 1));
    bus.HADDR  = $urandom;
  endtask

  // ---------------- AHB response monitor ----------------
  bit          busy_m = 0;
  int          waits_m;
  bit          resp_or, resp_and;
  logic [RW-1:0] e_r;

  always @(negedge PCLK) begin
    if (!PRST_N) begin
      busy_m = 0;
    end else begin
      if (busy_m) begin
        if (!bus.HREADYOUT) begin
          waits_m++;
          resp_or  = resp_or | bus.HRESP;
          resp_and = resp_and & bus.HRESP;
        end else begin
          chk("resp_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            e_r = exp_q.pop_front();
            chk("hresp", {63'd0, bus.HRESP}, {63'd0, e_r[35]});
            chk("hrdata", {32'd0, bus.HRDATA}, {32'd0, e_r[31:0]});
            chk("wait_states", 64'(waits_m), {61'd0, e_r[34:32]});
            chk("wait_hresp", {63'd0, (e_r[35] ? resp_and : ~resp_or)}, 64'd1);
          end
          busy_m = 0;
        end
      end else begin
        chk("idle_ready_okay", {62'd0, bus.HREADYOUT, bus.HRESP}, 64'd2);
      end
      if (bus.HSEL && bus.HTRANS[1] && bus.HREADYOUT) begin
        busy_m = 1; waits_m = 0; resp_or = 0; resp_and = 1;
      end
    end
  end

  // ---------------- APB monitor ----------------
  bit            apb_ph = 0;
  logic [AW-1:0] cur_a;
  logic [2:0]    exp_sel;

  always @(negedge PCLK) begin
    if (!PRST_N) begin
      apb_ph = 0;
    end else if (bus.PSEL != '0) begin
      chk("psel_onehot", 64'($countones(bus.PSEL)), 64'd1);
      if (!bus.PENABLE) begin
        chk("apb_setup_order", {63'd0, apb_ph}, 64'd0);
        chk("apb_q_nonempty", {63'd0, apb_q.size() != 0}, 64'd1);
        if (apb_q.size() != 0) cur_a = apb_q.pop_front();
        apb_ph = 1;
      end else begin
        chk("apb_access_order", {63'd0, apb_ph}, 64'd1);
        apb_ph = 0;
      end
      exp_sel = 3'd1 << cur_a[66:65];
      chk("apb_sel_dir", {60'd0, bus.PSEL, bus.PWRITE}, {60'd0, exp_sel, cur_a[64]});
      chk("apb_addr", {32'd0, bus.PADDR}, {32'd0, cur_a[63:32]});
      if (cur_a[64]) chk("apb_wdata", {32'd0, bus.PWDATA}, {32'd0, cur_a[31:0]});
    end else begin
      chk("apb_idle", {62'd0, bus.PENABLE, apb_ph}, 64'd0);
      apb_ph = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_psel_pen"}, {60'd0, bus.PSEL, bus.PENABLE}, 64'd0);
    chk({tag, "_pwdata"}, {32'd0, bus.PWDATA}, 64'd0);
    chk({tag, "_paddr_pwrite"}, {31'd0, bus.PADDR, bus.PWRITE}, 64'd0);
    chk({tag, "_hready_hresp"}, {62'd0, bus.HREADYOUT, bus.HRESP}, 64'd2);
    chk({tag, "_hrdata"}, {32'd0, bus.HRDATA}, 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    PRST_N = 1'b0;
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HADDR = 0; bus.HWDATA = 0;
    bus.PRDATA_BUS = '0;
    last_rd = '0; last_was_err = 0;
    for (int k = 0; k < NSLV; k++) slv_rd[k] = $urandom;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge PCLK);
    #1 PRST_N = 1'b1;

    // Directed: write to slave 1, read from slave 2, pipelined write->read.
    issue(1'b1, 32'h0000_1018, 32'hA5A5_0001, 1);
    slv_rd[0] = 32'hFFFF_FFFF; slv_rd[1] = 32'hFFFF_FFFF; slv_rd[2] = 32'h1234_5678;
    issue(1'b0, 32'h0000_2000, 32'h0, 1);
    issue(1'b1, 32'h0000_1000, $urandom, 1);
    slv_rd[0] = $urandom;
    issue(1'b0, 32'h0000_0000, 32'h0, 0);
    // Unmapped index, then a transfer offered in the second ERROR cycle.
    issue(1'b0, 32'h0000_3000, 32'h0, 1);
    issue(1'b0, 32'h0000_1004, 32'h0, 0);
    issue(1'b1, 32'hFFFF_3ABC, $urandom, 1);
    // Long run of IDLE/BUSY cycles before a normal read.
    issue(1'b0, 32'h0000_2ABC, 32'h0, 6);

    // Reset pulse during the ACCESS cycle of a write.
    issue(1'b1, 32'h0000_1ABC, 32'hDEAD_BEEF, 1);
    n = 0;
    while (!bus.PENABLE && n < 10) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("rst_reach_access", {63'd0, bus.PENABLE}, 64'd1);
    PRST_N = 1'b0;
    exp_q.delete(); apb_q.delete();
    last_rd = '0; last_was_err = 0;
    #1;
    check_reset_outputs("midrst");
    #6 PRST_N = 1'b1;
    @(posedge PCLK); #1;
    slv_rd[1] = $urandom;
    issue(1'b0, 32'h0000_1100, 32'h0, 1);
    issue(1'b1, 32'h0000_0100, $urandom, 0);

    // Random traffic.
    for (int t = 0; t < 250; t++) begin
      for (int k = 0; k < NSLV; k++) slv_rd[k] = $urandom;
      a = $urandom;
      issue(1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Drain.
    n = 0;
    while ((exp_q.size() != 0 || busy_m) && n < 100) begin
      @(posedge PCLK); #1;
      n++;
    end
    repeat (2) @(posedge PCLK);
    chk("resp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("apb_q_drained", 64'(apb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
